// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: common-bus arbiter for four cores (DL + IL caches each).
// A processor request is granted round-robin from rr_ptr; while a processor
// owns the bus, one snoop responder (lowest core index first) or lower-level
// memory may be granted the data bus on top of the processor grant.
//
// Optional feature: define COM_BUS_ARB_WATCHDOG_EN to bound how long a
// processor grant may be held (WDOG_CYCLES cycles, 1..255). Without it the
// watchdog counter is absent and Arb_timeout is tied low.
//
// Ports:
//   clk                 single clock, rising edge
//   rst_n               synchronous active-low reset
//   Com_Bus_Req_proc    [7:0] proc requests (0-3 DL cores 0-3, 4-7 IL cores 0-3)
//   Com_Bus_Req_snoop   [3:0] snoop-response requests, one per core
//   Mem_snoop_req       memory request to drive the data bus
//   Com_Bus_Gnt_proc    [7:0] proc grant, one-hot or zero
//   Com_Bus_Gnt_snoop   [3:0] snoop grant, one-hot or zero
//   Mem_snoop_gnt       memory grant
//   Arb_busy            high while a processor owns the bus
//   Arb_timeout         one-cycle pulse on watchdog expiry
module com_bus_arbiter #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Com_Bus_Req_proc,
  input  logic [3:0] Com_Bus_Req_snoop,
  input  logic       Mem_snoop_req,
  output logic [7:0] Com_Bus_Gnt_proc,
  output logic [3:0] Com_Bus_Gnt_snoop,
  output logic       Mem_snoop_gnt,
  output logic       Arb_busy,
  output logic       Arb_timeout
);

  localparam int unsigned NPROC = 8;
  localparam int unsigned NSNP  = 4;

  // Elaboration-time range check on the watchdog length.
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_bad_wdog
    $error("com_bus_arbiter: WDOG_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROC_OWN = 2'd1,
    RESP_OWN = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       rr_ptr_q;
  logic [2:0]       owner_q;
  logic [NPROC-1:0] gnt_proc_q;
  logic [NSNP-1:0]  gnt_snoop_q;
  logic             mem_gnt_q;
  logic             busy_q;

  logic [2:0]       pick_idx_c;
  logic             pick_vld_c;
  logic [2:0]       scan_idx_c;
  logic [NSNP-1:0]  snp_oh_c;
  logic             resp_req_c;
  logic             resp_hold_c;
  logic             owner_req_c;
  logic             wdog_exp_c;
  logic             end_own_c;

  // Round-robin pick: first proc requester at or after rr_ptr (mod 8).
  // Scanning from the far end lets the nearest requester overwrite last.
  always_comb begin
    pick_idx_c = '0;
    pick_vld_c = 1'b0;
    scan_idx_c = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      scan_idx_c = rr_ptr_q + 3'(i);
      if (Com_Bus_Req_proc[scan_idx_c]) begin
        pick_idx_c = scan_idx_c;
        pick_vld_c = 1'b1;
      end
    end
  end

  // Responder pick: lowest-index snoop request wins; memory only if none.
  always_comb begin
    snp_oh_c = '0;
    for (int i = NSNP - 1; i >= 0; i--) begin
      if (Com_Bus_Req_snoop[i]) begin
        snp_oh_c = NSNP'(1) << i;
      end
    end
  end

  assign resp_req_c  = (|Com_Bus_Req_snoop) | Mem_snoop_req;
  assign resp_hold_c = (|(gnt_snoop_q & Com_Bus_Req_snoop)) | (mem_gnt_q & Mem_snoop_req);
  assign owner_req_c = Com_Bus_Req_proc[owner_q];
  // Owner drop and watchdog expiry both end ownership; either beats a responder.
  assign end_own_c   = ~owner_req_c | wdog_exp_c;

`ifdef COM_BUS_ARB_WATCHDOG_EN
  logic [7:0] wdog_q;
  logic       timeout_q;

  assign wdog_exp_c  = (wdog_q == 8'(WDOG_CYCLES - 1));
  assign Arb_timeout = timeout_q;
`else
  assign wdog_exp_c  = 1'b0;
  assign Arb_timeout = 1'b0;
`endif

  // Arbiter FSM with registered grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      mem_gnt_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef COM_BUS_ARB_WATCHDOG_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef COM_BUS_ARB_WATCHDOG_EN
      timeout_q <= 1'b0;
      if (state_q != IDLE) begin
        wdog_q <= wdog_q + 8'd1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld_c) begin
            gnt_proc_q <= NPROC'(1) << pick_idx_c;
            owner_q    <= pick_idx_c;
            busy_q     <= 1'b1;
            state_q    <= PROC_OWN;
`ifdef COM_BUS_ARB_WATCHDOG_EN
            wdog_q     <= '0;
`endif
          end
        end
        PROC_OWN, RESP_OWN: begin
          if (end_own_c) begin
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= owner_q + 3'd1;
            state_q     <= IDLE;
`ifdef COM_BUS_ARB_WATCHDOG_EN
            timeout_q   <= owner_req_c;
`endif
          end else if (state_q == PROC_OWN) begin
            if (resp_req_c) begin
              if (|Com_Bus_Req_snoop) begin
                gnt_snoop_q <= snp_oh_c;
              end else begin
                mem_gnt_q <= 1'b1;
              end
              state_q <= RESP_OWN;
            end
          end else if (!resp_hold_c) begin
            // Responder released: drop its grant, keep the proc grant.
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            state_q     <= PROC_OWN;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Com_Bus_Gnt_proc  = gnt_proc_q;
  assign Com_Bus_Gnt_snoop = gnt_snoop_q;
  assign Mem_snoop_gnt     = mem_gnt_q;
  assign Arb_busy          = busy_q;

endmodule
